// File: rtl/chunk_pingpong_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// chunk_pingpong_ctrl_pkg
// Shared sizing and bank-state definitions for the Data_Chunk ping-pong
// sequencer and the compute-side controller that reads the same banks.
// ---------------------------------------------------------------------------
package chunk_pingpong_ctrl_pkg;

   localparam int BUS_SIZE        = 128;
   localparam int CHUNK_SIZE      = 512;
   localparam int PREFIX_SUM_SIZE = 64;

   // Beats (or segments) needed to cover one chunk at a given per-beat width.
   function automatic int cyc_num(input int chunk_size, input int beat_size);
      return chunk_size / beat_size;
   endfunction

   // Counter width that still works when a cycle count is 1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int WR_DAT_CYC_NUM = cyc_num(CHUNK_SIZE, BUS_SIZE);
   localparam int RD_DAT_CYC_NUM = cyc_num(CHUNK_SIZE, PREFIX_SUM_SIZE);
   localparam int WR_CNT_W       = cnt_width(WR_DAT_CYC_NUM);
   localparam int RD_CNT_W       = cnt_width(RD_DAT_CYC_NUM);

   typedef enum logic [1:0] {
      BANK_EMPTY = 2'd0,
      BANK_FILL  = 2'd1,
      BANK_FULL  = 2'd2
   } bank_state_e;

endpackage

// File: rtl/chunk_pingpong_ctrl_if.sv
// ---------------------------------------------------------------------------
// chunk_pingpong_ctrl_if
// Loader-side write handshake and consumer-side read handshake of the
// ping-pong sequencer.
//   in_valid_i / in_ready_o      loader beat handshake
//   bank_wr_valid_o, wr_count_o  per-bank write strobe and beat index
//   rd_valid_o / rd_adv_i        consumer segment handshake
//   rd_bank_o, rd_sparsemap_addr_o, rd_last_o  read bank / segment select
// slave = the sequencer, master = loader/consumer side.
// ---------------------------------------------------------------------------
interface chunk_pingpong_ctrl_if;
   import chunk_pingpong_ctrl_pkg::*;

   logic                in_valid_i;
   logic                in_ready_o;
   logic [1:0]          bank_wr_valid_o;
   logic [WR_CNT_W-1:0] wr_count_o;
   logic                rd_valid_o;
   logic                rd_adv_i;
   logic                rd_bank_o;
   logic [RD_CNT_W-1:0] rd_sparsemap_addr_o;
   logic                rd_last_o;

   modport slave (
      input  in_valid_i, rd_adv_i,
      output in_ready_o, bank_wr_valid_o, wr_count_o,
             rd_valid_o, rd_bank_o, rd_sparsemap_addr_o, rd_last_o
   );

   modport master (
      output in_valid_i, rd_adv_i,
      input  in_ready_o, bank_wr_valid_o, wr_count_o,
             rd_valid_o, rd_bank_o, rd_sparsemap_addr_o, rd_last_o
   );

endinterface

// File: rtl/chunk_bank_state.sv
// ---------------------------------------------------------------------------
// chunk_bank_state
// Fill/read status of one Data_Chunk bank.
//   clk_i, rst_ni   clock, async active-low reset
//   flush_i         synchronous return to EMPTY
//   beat_i          a write beat is accepted into this bank
//   fill_done_i     that beat is the last of the chunk
//   release_i       the last read segment of this bank was consumed
//   state_o         current bank state
//
// state      | meaning
// BANK_EMPTY | no valid data, writable
// BANK_FILL  | partially written, writable
// BANK_FULL  | complete chunk, readable, blocks writes
// ---------------------------------------------------------------------------
module chunk_bank_state
   import chunk_pingpong_ctrl_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        beat_i,
   input  logic        fill_done_i,
   input  logic        release_i,
   output bank_state_e state_o
);

   bank_state_e state_q, state_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= BANK_EMPTY;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = BANK_EMPTY;
      end else begin
         unique case (state_q)
            // fill_done can hit an EMPTY bank when a chunk is a single beat
            BANK_EMPTY: if (fill_done_i) state_d = BANK_FULL;
                        else if (beat_i) state_d = BANK_FILL;
            BANK_FILL:  if (fill_done_i) state_d = BANK_FULL;
            BANK_FULL:  if (release_i)   state_d = BANK_EMPTY;
            default:    state_d = BANK_EMPTY;
         endcase
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/chunk_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// chunk_pingpong_ctrl
// Ping-pong sequencer for two Data_Chunk banks: fills one bank from the
// loader while the consumer walks the other bank segment by segment.
//   clk_i, rst_ni  clock, async active-low reset
//   flush_i        synchronous flush, overrides any beat/advance that cycle
//   bus            write/read handshake bundle (slave modport)
//   bank_full_o    per-bank FULL status
// ---------------------------------------------------------------------------
module chunk_pingpong_ctrl
   import chunk_pingpong_ctrl_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        flush_i,
   chunk_pingpong_ctrl_if.slave        bus,
   output logic [1:0]                  bank_full_o
);

   logic                wr_bank_q, wr_bank_d;
   logic                rd_bank_q, rd_bank_d;
   logic [WR_CNT_W-1:0] wr_cnt_q,  wr_cnt_d;
   logic [RD_CNT_W-1:0] rd_cnt_q,  rd_cnt_d;

   bank_state_e bank_st [2];
   logic [1:0]  wr_sel, rd_sel;
   logic        beat, wr_last, rd_adv, rd_release;

   assign wr_sel = wr_bank_q ? 2'b10 : 2'b01;
   assign rd_sel = rd_bank_q ? 2'b10 : 2'b01;

   assign bus.in_ready_o = (bank_st[wr_bank_q] != BANK_FULL) && !flush_i;
   assign beat           = bus.in_valid_i && bus.in_ready_o;
   assign wr_last        = beat && (wr_cnt_q == WR_CNT_W'(WR_DAT_CYC_NUM - 1));

   assign bus.rd_valid_o = (bank_st[rd_bank_q] == BANK_FULL);
   assign rd_adv         = bus.rd_valid_o && bus.rd_adv_i;
   assign rd_release     = rd_adv && (rd_cnt_q == RD_CNT_W'(RD_DAT_CYC_NUM - 1));

   assign bus.bank_wr_valid_o     = beat ? wr_sel : 2'b00;
   assign bus.wr_count_o          = wr_cnt_q;
   assign bus.rd_bank_o           = rd_bank_q;
   assign bus.rd_sparsemap_addr_o = rd_cnt_q;
   assign bus.rd_last_o           = bus.rd_valid_o &&
                                    (rd_cnt_q == RD_CNT_W'(RD_DAT_CYC_NUM - 1));

   // Explicit compare-and-clear so non-power-of-2 cycle counts wrap correctly.
   always_comb begin
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      if (flush_i) begin
         wr_bank_d = 1'b0;
         rd_bank_d = 1'b0;
         wr_cnt_d  = '0;
         rd_cnt_d  = '0;
      end else begin
         if (wr_last) begin
            wr_cnt_d  = '0;
            wr_bank_d = ~wr_bank_q;
         end else if (beat) begin
            wr_cnt_d  = wr_cnt_q + 1'b1;
         end
         if (rd_release) begin
            rd_cnt_d  = '0;
            rd_bank_d = ~rd_bank_q;
         end else if (rd_adv) begin
            rd_cnt_d  = rd_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
      end else begin
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
      end
   end

   chunk_bank_state u_bank0 (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .beat_i      (beat && wr_sel[0]),
      .fill_done_i (wr_last && wr_sel[0]),
      .release_i   (rd_release && rd_sel[0]),
      .state_o     (bank_st[0])
   );

   chunk_bank_state u_bank1 (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .beat_i      (beat && wr_sel[1]),
      .fill_done_i (wr_last && wr_sel[1]),
      .release_i   (rd_release && rd_sel[1]),
      .state_o     (bank_st[1])
   );

   assign bank_full_o = {bank_st[1] == BANK_FULL, bank_st[0] == BANK_FULL};

endmodule

// File: doc/chunk_pingpong_ctrl.md
Name: chunk_pingpong_ctrl

Overview:
- Sequencer for two Data_Chunk banks (bank 0/1) used as a ping-pong buffer in front of the prefix-sum/sparse compute path.
- Write side: accepts BUS_SIZE-wide beats from the loader via valid/ready and generates per-bank wr_valid/wr_count so each bank fills in WR_DAT_CYC_NUM beats.
- Read side: presents a full bank to the consumer, steps rd_sparsemap_addr through RD_DAT_CYC_NUM segments under consumer handshake, then releases the bank for refill.
- Filling one bank while the other is read is the normal steady state.

Parameters:
- BUS_SIZE, 128, sparsemap bits / nonzero bytes per write beat.
- CHUNK_SIZE, 512, elements per chunk.
- PREFIX_SUM_SIZE, 64, sparsemap bits per read segment.
- WR_DAT_CYC_NUM, CHUNK_SIZE/BUS_SIZE (=4), derived localparam.
- RD_DAT_CYC_NUM, CHUNK_SIZE/PREFIX_SUM_SIZE (=8), derived localparam.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- flush_i  in  1  synchronous flush: all banks EMPTY, all counters 0.
- in_valid_i  in  1  loader beat valid.
- in_ready_o  out  1  beat accepted when in_valid_i && in_ready_o.
- bank_wr_valid_o  out  2  one-hot wr_valid for bank 0/1; 0 when no beat is accepted.
- wr_count_o  out  $clog2(WR_DAT_CYC_NUM)  beat index within the chunk, shared by both banks.
- rd_valid_o  out  1  current read bank is FULL and a segment is presented.
- rd_adv_i  in  1  consumer finished the current segment; takes effect only when rd_valid_o=1.
- rd_bank_o  out  1  bank being read; selects the rd_data/rd_sparsemap mux.
- rd_sparsemap_addr_o  out  $clog2(RD_DAT_CYC_NUM)  segment index.
- rd_last_o  out  1  rd_valid_o && segment == RD_DAT_CYC_NUM-1.
- bank_full_o  out  2  per-bank FULL status (debug/perf).

Behaviour:
- Per-bank state: EMPTY, FILL, FULL. Pointers: wr_bank, rd_bank; counters: wr_cnt, rd_cnt.
- Reset (async, rst_ni=0): both banks EMPTY, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0. All outputs 0 except in_ready_o=1 after reset deasserts.
- in_ready_o = (state[wr_bank] != FULL) && !flush_i. Combinational; no dependence on in_valid_i.
- bank_wr_valid_o[wr_bank] = in_valid_i && in_ready_o, combinational; wr_count_o = wr_cnt. Data goes straight from the loader to Data_Chunk and is captured at the same edge.
- On an accepted beat:
  - EMPTY -> FILL on the first beat; wr_cnt increments.
  - If wr_cnt == WR_DAT_CYC_NUM-1: bank -> FULL, wr_cnt -> 0, wr_bank toggles.
- rd_valid_o = (state[rd_bank] == FULL), registered state. Latency: rd_valid_o rises the cycle after the last write beat edge (1 cycle).
- On rd_valid_o && rd_adv_i: rd_cnt increments. If rd_cnt == RD_DAT_CYC_NUM-1: bank -> EMPTY, rd_cnt -> 0, rd_bank toggles.
  - A released bank accepts beats from the next cycle (in_ready_o may rise 1 cycle after the last rd_adv).
- rd_adv_i while rd_valid_o=0: ignored.
- Simultaneous events:
  - Last write beat on one bank and last read advance on the other in the same cycle: both take effect.
  - The same bank cannot be both written and read, because FULL blocks writes and non-FULL blocks reads.
- Both banks FULL: in_ready_o=0 until the read side releases a bank.
- Counter wrap is an explicit compare-and-clear, never natural overflow, so non-power-of-2 cycle counts are legal.
- flush_i: same effect as reset at the next edge and has priority over any beat or advance in that cycle. A beat presented in the flush cycle is not accepted.
- Reset mid-chunk: partial data is abandoned; the next chunk starts at bank 0, beat 0. The stale Data_Chunk contents are fully overwritten before the bank is next read.

Decomposition:
- Shared package: bank-state enum (EMPTY/FILL/FULL) and the WR_DAT_CYC_NUM/RD_DAT_CYC_NUM derivation functions, for reuse by the compute-side controller.
- One natural sub-module: chunk_bank_state, a per-bank 2-bit FSM with fill_done/release inputs, instantiated twice. Pointers and counters stay in the top.

Test Plan:
- Reset, then 4 consecutive beats -> bank_wr_valid_o=01 with wr_count_o=0,1,2,3; rd_valid_o=1 one cycle after beat 3, rd_bank_o=0, rd_sparsemap_addr_o=0.
- Hold rd_adv_i=1 for 8 cycles -> addr steps 0..7, rd_last_o only at 7; bank 0 then EMPTY and rd_bank_o=1.
- Load 8 beats with no rd_adv -> bank_full_o=11 and in_ready_o=0 with in_valid_i held; one full read of bank 0 -> in_ready_o=1 next cycle and the next beat goes to bank 0 at wr_count_o=0.
- Last write beat to bank 1 in the same cycle as the last rd_adv on bank 0 -> next cycle bank_full_o=10, rd_bank_o=1, wr_bank=0.
- Random in_valid_i/rd_adv_i gaps over 20 chunks -> chunk order and beat/segment indices match a scoreboard; no write to a FULL bank.
- rst_ni pulsed low mid-beat 2 (and separately flush_i during read segment 5) -> all outputs 0 immediately (async) or at the next edge (flush); the next load begins at bank 0, count 0.
